// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared multi-cycle ALU: grant, issue, wait ALU_LAT, return result.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_a,
    input  logic [DATA_WIDTH-1:0]   req0_b,
    input  logic [2:0]              req0_oper,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_a,
    input  logic [DATA_WIDTH-1:0]   req1_b,
    input  logic [2:0]              req1_oper,
    output logic                    rsp0_valid,
    output logic [2*DATA_WIDTH-1:0] rsp0_res,
    output logic                    rsp1_valid,
    output logic [2*DATA_WIDTH-1:0] rsp1_res,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [2:0]              alu_oper,
    output logic                    alu_execute,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]              oper_q, oper_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic                    accept;
    logic                    gnt_idx;
    logic                    rsp_fire;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_idx = !req0_valid;
    end
`else
    logic last_grant_q, last_grant_d;

    // Only a genuine tie consults history; a lone requester always wins.
    always_comb begin
        gnt_idx      = (req0_valid && req1_valid) ? !last_grant_q : !req0_valid;
        last_grant_d = rsp_fire ? owner_q : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif

    // Gating with reset keeps ready low while reset is held and valids are up.
    assign accept = (state_q == IDLE) && (req0_valid || req1_valid) && !reset;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        oper_d      = oper_q;
        res_d       = res_q;
        alu_execute = 1'b0;
        rsp_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt_idx;
                    a_d     = gnt_idx ? req1_a    : req0_a;
                    b_d     = gnt_idx ? req1_b    : req0_b;
                    oper_d  = gnt_idx ? req1_oper : req0_oper;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                alu_execute = 1'b1;
                cnt_d       = CNT_LOAD;
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_res;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_fire = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            oper_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oper_q  <= oper_d;
            res_q   <= res_d;
        end
    end

    assign req0_ready = accept && !gnt_idx;
    assign req1_ready = accept && gnt_idx;
    assign rsp0_valid = rsp_fire && !owner_q;
    assign rsp1_valid = rsp_fire && owner_q;
    assign rsp0_res   = rsp0_valid ? res_q : '0;
    assign rsp1_res   = rsp1_valid ? res_q : '0;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_oper   = oper_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: transaction-level arbiter model plus response scoreboard.
module tb_alu_arbiter;

    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_oper, req1_oper;
    logic          rsp0_valid, rsp1_valid;
    logic [2*DW-1:0] rsp0_res, rsp1_res;
    logic [DW-1:0] alu_a, alu_b;
    logic [2:0]    alu_oper;
    logic          alu_execute;
    logic [2*DW-1:0] alu_res;
    logic          busy;

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_oper(req1_oper),
        .rsp0_valid(rsp0_valid), .rsp0_res(rsp0_res), .rsp1_valid(rsp1_valid), .rsp1_res(rsp1_res),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_execute(alu_execute),
        .alu_res(alu_res), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [2*DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd0:    return a * b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return ~{a, b};
            default: return {a, b};
        endcase
    endfunction

    // Shared ALU: the true result is present only in the single cycle LAT after the start pulse.
    int              alu_due = -1;
    logic [2*DW-1:0] alu_pend = '0;
    always @(negedge clk) begin
        if (reset) alu_due = -1;
        else if (alu_execute) begin
            alu_pend = alu_f(alu_a, alu_b, alu_oper);
            alu_due  = cyc + LAT;
        end
        alu_res = (cyc == alu_due) ? alu_pend : 16'($urandom);
    end

    typedef struct {
        int              owner;
        logic [2*DW-1:0] res;
        int              due;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (rsp0_valid || rsp1_valid) begin
                check("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 0);
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_owner", {31'd0, rsp1_valid}, e.owner);
                    check("rsp_res", rsp1_valid ? rsp1_res : rsp0_res, e.res);
                    check("rsp_cycle", cyc, e.due);
                end
            end
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                check("rsp_missing", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    // Requester-side state and the abstract arbiter model (free-at cycle, last winner).
    bit         v[2];
    bit         granted[2];
    logic [7:0] ra[2], rb[2];
    logic [2:0] rop[2];
    int         next_free = 0;
    int         acc_cyc   = -100;
    int         last_win  = 1;
    logic [7:0] acc_a, acc_b;
    logic [2:0] acc_op;
    bit         dir_left;
    logic [7:0] dir_a, dir_b;
    logic [2:0] dir_op;
    bit         reset_req = 0;

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 0);
        check({tag, "_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 0);
        check({tag, "_res"}, {rsp1_res, rsp0_res}, 0);
        check({tag, "_alu"}, {alu_execute, alu_oper, alu_b, alu_a}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic step(input int mode);
        bit free;
        int w;
        @(posedge clk);
        #1;
        if (reset) reset = 1'b0;
        free = (cyc >= next_free);
        for (int i = 0; i < 2; i++) begin
            if (granted[i] || !v[i] || mode >= 2) begin
                case (mode)
                    0:       v[i] = 1'($urandom_range(0, 1));
                    1:       v[i] = 1'b1;
                    2:       v[i] = (i == 1);
                    3:       v[i] = (i == 0) && dir_left;
                    default: v[i] = 1'b0;
                endcase
                ra[i]  = 8'($urandom);
                rb[i]  = 8'($urandom);
                rop[i] = 3'($urandom);
                if (mode == 3 && i == 0) begin
                    ra[i] = dir_a; rb[i] = dir_b; rop[i] = dir_op;
                end
            end else if (!free && mode == 0 && $urandom_range(0, 4) == 0) begin
                v[i] = 1'b0;
            end
            granted[i] = 1'b0;
        end
        req0_valid = v[0]; req0_a = ra[0]; req0_b = rb[0]; req0_oper = rop[0];
        req1_valid = v[1]; req1_a = ra[1]; req1_b = rb[1]; req1_oper = rop[1];
        #1;
        w = -1;
        if (free && (v[0] || v[1])) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = v[0] ? 0 : 1;
`else
            w = (v[0] && v[1]) ? 1 - last_win : (v[0] ? 0 : 1);
`endif
        end
        check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
        check("busy", {31'd0, busy}, {31'd0, !free});
        check("alu_execute", {31'd0, alu_execute}, {31'd0, cyc == acc_cyc + 1});
        if (cyc == acc_cyc + 1)
            check("alu_operands", {alu_oper, alu_b, alu_a}, {acc_op, acc_b, acc_a});
        if (w >= 0) begin
            exp_t e;
            e.owner = w;
            e.res   = alu_f(ra[w], rb[w], rop[w]);
            e.due   = cyc + LAT + 2;
            sbq.push_back(e);
            acc_a = ra[w]; acc_b = rb[w]; acc_op = rop[w];
            next_free  = cyc + LAT + 3;
            acc_cyc    = cyc;
            last_win   = w;
            granted[w] = 1'b1;
            if (mode == 3 && w == 0) dir_left = 1'b0;
        end
        // Abort an operation in flight while it waits on the ALU.
        if (reset_req && cyc == acc_cyc + 2) begin
            reset_req = 0;
            reset = 1'b1;
            #1;
            check_all_zero("midop_reset");
            sbq.delete();
            next_free = 0;
            acc_cyc   = -100;
            last_win  = 1;
        end
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        dir_a = a; dir_b = b; dir_op = op; dir_left = 1'b1;
        for (int k = 0; k < 8; k++) step(3);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'hAA; req0_b = 8'h55; req0_oper = 3'd1;
        req1_a = 8'h11; req1_b = 8'h22; req1_oper = 3'd2;
        alu_res = '0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        v[0] = 0; v[1] = 0; granted[0] = 0; granted[1] = 0;
        directed(8'd5, 8'd3, 3'd0);
        directed(8'hFF, 8'hFE, 3'd7);
        for (int k = 0; k < 25; k++) step(1);
        for (int k = 0; k < 25; k++) step(2);
        reset_req = 1;
        for (int k = 0; k < 30; k++) step(1);
        check("midop_reset_hit", {31'd0, reset_req}, 0);
        for (int k = 0; k < 300; k++) step(0);
        for (int k = 0; k < 10; k++) step(4);
        check("drain_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
